mul_16bit_seq: RTL

MUL_16BIT_SEQ -- requirements
Module: mul_16bit_seq

---
 rtl/alu_pkg.sv | 11 +
 rtl/mul_step.sv | 40 ++++
 rtl/mul_16bit_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential multiplier.
package alu_pkg;
  localparam int N = 16;
  localparam logic [4:0] CNT_LAST = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_step.sv
// One combinational multiply iteration: conditional add/subtract of the multiplicand, then shift right.
// MUL_SIGNED_EN selects radix-2 Booth (signed); otherwise unsigned shift-add.
module mul_step #(
  parameter int N = alu_pkg::N
) (
  input  logic [N-1:0] i_a,
  input  logic [N:0]   i_acc,
  input  logic [N-1:0] i_q,
`ifdef MUL_SIGNED_EN
  input  logic         i_qm1,
  output logic         o_qm1_n,
`endif
  output logic [N:0]   o_acc_n,
  output logic [N-1:0] o_q_n
);
  logic [N:0] w_sum;

`ifdef MUL_SIGNED_EN
  logic [N:0] w_a_ext;
  assign w_a_ext = {i_a[N-1], i_a};

  // Booth pair {q[0], q[-1]}: 10 subtract, 01 add, else pass through.
  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_qm1})
      2'b10:   w_sum = i_acc - w_a_ext;
      2'b01:   w_sum = i_acc + w_a_ext;
      default: w_sum = i_acc;
    endcase
  end

  assign o_acc_n = {w_sum[N], w_sum[N:1]};
  assign o_qm1_n = i_q[0];
`else
  assign w_sum   = i_acc + (i_q[0] ? {1'b0, i_a} : {(N+1){1'b0}});
  assign o_acc_n = {1'b0, w_sum[N:1]};
`endif

  assign o_q_n = {w_sum[0], i_q[N-1:1]};
endmodule

// File: rtl/mul_16bit_seq.sv
// Sequential 16x16 multiplier: one step per cycle, done pulses 17 cycles after an accepted start.
// Macro MUL_SIGNED_EN: signed Booth operands; default is unsigned shift-add.
module mul_16bit_seq #(
  parameter int N = alu_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);
  import alu_pkg::*;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_load;
  logic           w_step;
  logic           w_last;

  logic [N-1:0]   r_a;
  logic [N:0]     r_acc;
  logic [N-1:0]   r_q;
  logic [4:0]     r_cnt;
  logic [2*N-1:0] r_prod;

  logic [N:0]     w_acc_n;
  logic [N-1:0]   w_q_n;

`ifdef MUL_SIGNED_EN
  logic           r_qm1;
  logic           w_qm1_n;
`endif

  mul_step #(.N(N)) u_step (
    .i_a     (r_a),
    .i_acc   (r_acc),
    .i_q     (r_q),
`ifdef MUL_SIGNED_EN
    .i_qm1   (r_qm1),
    .o_qm1_n (w_qm1_n),
`endif
    .o_acc_n (w_acc_n),
    .o_q_n   (w_q_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Start is honoured in DONE as well, giving back-to-back runs with no IDLE gap.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
`ifdef MUL_SIGNED_EN
      r_qm1  <= 1'b0;
`endif
    end else if (w_load) begin
      r_a    <= a;
      r_acc  <= '0;
      r_q    <= b;
      r_cnt  <= '0;
`ifdef MUL_SIGNED_EN
      r_qm1  <= 1'b0;
`endif
    end else if (w_step) begin
      r_acc  <= w_acc_n;
      r_q    <= w_q_n;
      r_cnt  <= r_cnt + 5'd1;
`ifdef MUL_SIGNED_EN
      r_qm1  <= w_qm1_n;
`endif
      // The product register only moves on the final step, so it holds between runs.
      if (w_last) begin
        r_prod <= {w_acc_n[N-1:0], w_q_n};
      end
    end
  end

  assign prod = r_prod;
endmodule
